// File: rtl/khazad_pkg.sv
// Shared types and constants for the KHAZAD block sequencer.
// Optional watchdog is enabled with `KHAZAD_SEQ_WATCHDOG_EN.
package khazad_pkg;

  localparam int unsigned BLK_W = 64;
  localparam int unsigned KEY_W = 128;

  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;
  localparam logic DIR_DEC  = 1'b0;
  localparam logic DIR_ENC  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_OUT
  } seq_state_e;

endpackage

// File: rtl/khazad_seq_watchdog.sv
// Cycle watchdog for the sequencer WAIT state; expire rises on the
// TIMEOUT-th consecutive enabled cycle and stays until clear.
module khazad_seq_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign expire = en && !clr && (cnt_q >= TIMEOUT - 32'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/khazad_block_sequencer.sv
// Valid/ready stream sequencer in front of the KHAZAD ECB/CBC core.
// Define KHAZAD_SEQ_WATCHDOG_EN to bound the wait for core_last_round.
module khazad_block_sequencer
  import khazad_pkg::*;
`ifdef KHAZAD_SEQ_WATCHDOG_EN
  #(parameter int unsigned TIMEOUT = 64)
`endif
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cfg_load,
  input  logic [KEY_W-1:0]     cfg_key,
  input  logic [BLK_W-1:0]     cfg_iv,
  input  logic                 cfg_enc_dec,
  input  logic                 cfg_op_mode,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [BLK_W-1:0]     s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [BLK_W-1:0]     m_data,
  output logic                 m_last,
  output logic [BLK_W-1:0]     core_d_in,
  output logic [KEY_W-1:0]     core_k_in,
  output logic [BLK_W-1:0]     core_iv,
  output logic                 core_enc_dec,
  output logic                 core_op_mode,
  output logic                 core_first_block,
  output logic                 core_only_data,
  output logic                 core_start,
  input  logic [BLK_W-1:0]     core_d_out,
  input  logic                 core_last_round,
  output logic [31:0]          blk_cnt,
  output logic                 err
);

  seq_state_e         state_q, state_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic [BLK_W-1:0]   m_data_q, m_data_d;
  logic               m_last_q, m_last_d;
  logic [BLK_W-1:0]   d_in_q, d_in_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [BLK_W-1:0]   iv_q, iv_d;
  logic               enc_dec_q, enc_dec_d;
  logic               op_mode_q, op_mode_d;
  logic               first_block_q, first_block_d;
  logic               only_data_q, only_data_d;
  logic               start_q, start_d;
  logic [31:0]        blk_cnt_q, blk_cnt_d;
  logic               err_q, err_d;
  logic               key_fresh_q, key_fresh_d;
  logic               msg_start_q, msg_start_d;
  logic               wd_expire;

`ifdef KHAZAD_SEQ_WATCHDOG_EN
  khazad_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (CLK),
    .rst_n  (RST),
    .en     (state_q == ST_WAIT),
    .clr    (state_q != ST_WAIT),
    .expire (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_last_d      = m_last_q;
    d_in_d        = d_in_q;
    key_d         = key_q;
    iv_d          = iv_q;
    enc_dec_d     = enc_dec_q;
    op_mode_d     = op_mode_q;
    first_block_d = first_block_q;
    only_data_d   = only_data_q;
    start_d       = 1'b0;
    blk_cnt_d     = blk_cnt_q;
    err_d         = err_q;
    key_fresh_d   = key_fresh_q;
    msg_start_d   = msg_start_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          key_d       = cfg_key;
          iv_d        = cfg_iv;
          enc_dec_d   = cfg_enc_dec;
          op_mode_d   = cfg_op_mode;
          key_fresh_d = 1'b1;
          msg_start_d = 1'b1;
        end
        // Block flags are frozen at accept so they stay stable through OUT,
        // and see a cfg_load arriving in the same cycle.
        if (s_valid && s_ready_q) begin
          d_in_d        = s_data;
          m_last_d      = s_last;
          only_data_d   = ~key_fresh_d;
          first_block_d = msg_start_d;
          start_d       = 1'b1;
          state_d       = ST_START;
        end
      end
      ST_START: begin
        key_fresh_d = 1'b0;
        state_d     = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_last_round) begin
          m_data_d  = core_d_out;
          m_valid_d = 1'b1;
          state_d   = ST_OUT;
        end else if (wd_expire) begin
          m_data_d  = '0;
          m_valid_d = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_OUT;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          m_valid_d   = 1'b0;
          blk_cnt_d   = blk_cnt_q + 32'd1;
          msg_start_d = m_last_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cfg_load && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end

    s_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_IDLE;
      s_ready_q     <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_last_q      <= 1'b0;
      d_in_q        <= '0;
      key_q         <= '0;
      iv_q          <= '0;
      enc_dec_q     <= DIR_DEC;
      op_mode_q     <= MODE_ECB;
      first_block_q <= 1'b1;
      only_data_q   <= 1'b1;
      start_q       <= 1'b0;
      blk_cnt_q     <= '0;
      err_q         <= 1'b0;
      key_fresh_q   <= 1'b0;
      msg_start_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      s_ready_q     <= s_ready_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_last_q      <= m_last_d;
      d_in_q        <= d_in_d;
      key_q         <= key_d;
      iv_q          <= iv_d;
      enc_dec_q     <= enc_dec_d;
      op_mode_q     <= op_mode_d;
      first_block_q <= first_block_d;
      only_data_q   <= only_data_d;
      start_q       <= start_d;
      blk_cnt_q     <= blk_cnt_d;
      err_q         <= err_d;
      key_fresh_q   <= key_fresh_d;
      msg_start_q   <= msg_start_d;
    end
  end

  assign s_ready          = s_ready_q;
  assign m_valid          = m_valid_q;
  assign m_data           = m_data_q;
  assign m_last           = m_last_q;
  assign core_d_in        = d_in_q;
  assign core_k_in        = key_q;
  assign core_iv          = iv_q;
  assign core_enc_dec     = enc_dec_q;
  assign core_op_mode     = op_mode_q;
  assign core_first_block = first_block_q;
  assign core_only_data   = only_data_q;
  assign core_start       = start_q;
  assign blk_cnt          = blk_cnt_q;
  assign err              = err_q;

endmodule
